// File: rtl/blinker_nios2_jtag_debug_host.sv
// ============================================================================
// Module      : blinker_nios2_jtag_debug_host
// Description : Command/response host that drives one virtual-JTAG IR+DR scan
//               per command. It generates tck, shifts data LSB first and
//               returns the captured tdo bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blinker_nios2_jtag_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,

    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int C_TICK_W = (2 * TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;
    localparam int C_BIT_W  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(2 * TCK_HALF - 1);
    localparam logic [C_TICK_W-1:0] C_TICK_RISE = C_TICK_W'(TCK_HALF - 1);
    localparam logic [C_TICK_W-1:0] C_TICK_HIGH = C_TICK_W'(TCK_HALF);
    localparam logic [C_TICK_W-1:0] C_TICK_ONE  = C_TICK_W'(1);
    localparam logic [C_BIT_W-1:0]  C_BIT_LAST  = C_BIT_W'(DR_WIDTH - 1);
    localparam logic [C_BIT_W-1:0]  C_BIT_ONE   = C_BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5,
        RSP  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [C_TICK_W-1:0]   r_tick;
    logic [C_TICK_W-1:0]   w_tick_next;
    logic [C_BIT_W-1:0]    r_bit;
    logic [DR_WIDTH-1:0]   r_sr;
    logic [DR_WIDTH:0]     w_shift;
    logic [DR_WIDTH-1:0]   r_rsp_data;
    logic                  r_rsp_valid;
    logic [IR_WIDTH-1:0]   r_ir;
    logic                  r_tck;
    logic                  r_tdi;

    logic                  w_active;
    logic                  w_next_active;
    logic                  w_step_end;
    logic                  w_tck_rise;
    logic                  w_bit_last;
    logic                  w_cmd_fire;
    logic                  w_rsp_fire;

    // Scan states run the tick divider; IDLE and RSP keep tck parked low.
    assign w_active      = (r_state inside {UIR, CDR, SDR, UDR, RTI});
    assign w_next_active = (w_state_next inside {UIR, CDR, SDR, UDR, RTI});
    assign w_step_end    = w_active && (r_tick == C_TICK_LAST);
    assign w_tck_rise    = (r_state == SDR) && (r_tick == C_TICK_RISE);
    assign w_bit_last    = (r_bit == C_BIT_LAST);
    assign w_cmd_fire    = cmd_valid && (r_state == IDLE);
    assign w_rsp_fire    = r_rsp_valid && rsp_ready;
    assign w_tick_next   = (w_active && !w_step_end) ? (r_tick + C_TICK_ONE) : '0;

    // Extra top bit lets the same slice serve DR_WIDTH == 1.
    assign w_shift       = {vji_tdo, r_sr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)                 w_state_next = UIR;
            UIR:     if (w_step_end)                w_state_next = CDR;
            CDR:     if (w_step_end)                w_state_next = SDR;
            SDR:     if (w_step_end && w_bit_last)  w_state_next = UDR;
            UDR:     if (w_step_end)                w_state_next = RTI;
            RTI:     if (w_step_end)                w_state_next = RSP;
            RSP:     if (w_rsp_fire)                w_state_next = IDLE;
            default:                                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick      <= '0;
            r_bit       <= '0;
            r_sr        <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_ir        <= '0;
            r_tck       <= 1'b0;
            r_tdi       <= 1'b0;
        end else begin
            r_tick <= w_tick_next;
            // tck is registered from the next tick so it never glitches.
            r_tck  <= w_next_active && (w_tick_next >= C_TICK_HIGH);

            if (w_cmd_fire) begin
                r_ir <= cmd_ir;
                r_sr <= cmd_data;
            end else if (w_tck_rise) begin
                r_sr <= w_shift[DR_WIDTH:1];
            end

            if (r_state != SDR) begin
                r_bit <= '0;
            end else if (w_step_end) begin
                r_bit <= w_bit_last ? '0 : (r_bit + C_BIT_ONE);
            end

            // tdi only moves at a step start; the shift already happened
            // mid-step, so sr[0] is the next bit to present.
            if (w_state_next != SDR) begin
                r_tdi <= 1'b0;
            end else if ((r_state != SDR) || w_step_end) begin
                r_tdi <= r_sr[0];
            end

            if ((r_state == RTI) && w_step_end) begin
                r_rsp_data  <= r_sr;
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign vji_tck   = r_tck;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir;
    assign vji_uir   = (r_state == UIR);
    assign vji_cdr   = (r_state == CDR);
    assign vji_sdr   = (r_state == SDR);
    assign vji_udr   = (r_state == UDR);
    assign vji_rti   = (r_state == RTI);

endmodule

`default_nettype wire

// File: tb/tb_blinker_nios2_jtag_debug_host.sv
// ============================================================================
// Module      : tb_blinker_nios2_jtag_debug_host
// Description : Scoreboard bench for the virtual-JTAG debug host scan engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blinker_nios2_jtag_debug_host;

    localparam int W = 38;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_ir;
    logic [W-1:0]  cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [1:0]    vji_ir_in;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic          tdo_loop, tdo_const;

    logic          c1_valid, c1_ready, r1_valid, r1_ready;
    logic [1:0]    c1_ir, ir1;
    logic [0:0]    c1_data, r1_data;
    logic          tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
    logic          tdo1;

    assign vji_tdo = tdo_loop ? vji_tdi : tdo_const;
    assign tdo1    = 1'b1;

    always #5 clk = ~clk;

    blinker_nios2_jtag_debug_host u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    blinker_nios2_jtag_debug_host #(.DR_WIDTH(1), .IR_WIDTH(2), .TCK_HALF(1)) u_dut_narrow (
        .clk(clk), .reset(reset),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_data(c1_data),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data(r1_data),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir1),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   ir;
        int           hs;
        int           tdi_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   resp_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: accumulates per-scan activity and checks each response.
    int           n_uir, n_cdr, n_sdr, n_udr, n_rti, n_ovl, n_tck, n_tdi;
    logic         prev_tck = 1'b0;
    logic         prev_rv = 1'b0;
    logic [W-1:0] held;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
            n_ovl = 0; n_tck = 0; n_tdi = 0;
        end else begin
            n_uir += int'(vji_uir);
            n_cdr += int'(vji_cdr);
            n_sdr += int'(vji_sdr);
            n_udr += int'(vji_udr);
            n_rti += int'(vji_rti);
            if (int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti) > 1)
                n_ovl++;
            if (vji_tck && !prev_tck) n_tck++;
            if (vji_sdr && vji_tdi) n_tdi++;
        end
        prev_tck = vji_tck;

        if (rsp_valid && !prev_rv) begin
            held = rsp_data;
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                chk("rsp_latency", 64'(cyc - q[0].hs), 64'd168);
                chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
                chk("ir_in", 64'(vji_ir_in), 64'(q[0].ir));
                chk("uir_cycles", 64'(n_uir), 64'd4);
                chk("cdr_cycles", 64'(n_cdr), 64'd4);
                chk("sdr_cycles", 64'(n_sdr), 64'd152);
                chk("udr_cycles", 64'(n_udr), 64'd4);
                chk("rti_cycles", 64'(n_rti), 64'd4);
                chk("ind_overlap", 64'(n_ovl), 64'd0);
                chk("tck_rises", 64'(n_tck), 64'd42);
                chk("tdi_high_cycles", 64'(n_tdi), 64'(q[0].tdi_cyc));
            end
        end else if (rsp_valid && prev_rv) begin
            chk("rsp_hold", 64'(rsp_data), 64'(held));
        end

        if (rsp_valid && rsp_ready && q.size() != 0) begin
            void'(q.pop_front());
            resp_hs = cyc + 1;
        end
        prev_rv = rsp_valid;
    end

    task automatic send_cmd(input logic [1:0] ir, input logic [W-1:0] data,
                            input logic [W-1:0] exp_data, input int exp_tdi, input bit push);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_ir = ir; cmd_data = data;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        else if (push) q.push_back('{exp_data, ir, cyc + 1, exp_tdi});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 2000) begin @(negedge clk); n++; end
        if (q.size() != 0 || rsp_valid) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 64'({rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr,
                       vji_sdr, vji_udr, vji_rti}), 64'd0);
        chk({name, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int n, bad, hs;
        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
        tdo_loop = 1'b1; tdo_const = 1'b0;
        c1_valid = 1'b0; c1_ir = '0; c1_data = '0; r1_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_state");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Loopback scan returns the shifted-in word.
        @(posedge clk); #1 rsp_ready = 1'b1;
        send_cmd(2'b01, 38'h2A_5555_5555, 38'h2A_5555_5555, 76, 1'b1);
        drain();
        chk("ir_hold_idle", 64'(vji_ir_in), 64'd1);

        // tdo tied high, zero data.
        tdo_loop = 1'b0; tdo_const = 1'b1;
        send_cmd(2'b10, 38'h0, 38'h3F_FFFF_FFFF, 0, 1'b1);
        drain();

        // Back-pressured response with a second command waiting.
        tdo_loop = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        send_cmd(2'b11, 38'h00_0000_000F, 38'h00_0000_000F, 16, 1'b1);
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("rsp_wait_timeout", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_ir = 2'b10; cmd_data = 38'h3F_0000_0001;
        bad = 0;
        repeat (50) begin @(negedge clk); if (cmd_ready) bad++; end
        chk("cmd_ready_low_in_rsp", 64'(bad), 64'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("second_accept_timeout", 64'(cmd_ready), 64'd1);
        end else begin
            hs = cyc + 1;
            q.push_back('{38'h3F_0000_0001, 2'b10, hs, 28});
            chk("accept_after_rsp_hs", 64'(hs - resp_hs), 64'd1);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        drain();

        // Reset in the middle of SDR step 10 aborts the scan.
        send_cmd(2'b01, 38'h12_3456_789A, 38'h0, 0, 1'b0);
        n = 0;
        while (!vji_sdr && n < 100) begin @(negedge clk); n++; end
        repeat (41) @(negedge clk);
        chk("in_sdr_before_reset", 64'(vji_sdr), 64'd1);
        #1 reset = 1'b1;
        #1 chk_outputs_zero("mid_scan_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 64'(cmd_ready), 64'd1);
        repeat (200) @(negedge clk);
        send_cmd(2'b10, 38'h2A_5555_5555, 38'h2A_5555_5555, 76, 1'b1);
        drain();

        // Narrow instance: one-bit DR, one-cycle half period.
        @(posedge clk); #1 c1_valid = 1'b1; c1_data = 1'b0;
        @(negedge clk);
        chk("narrow_ready", 64'(c1_ready), 64'd1);
        hs = cyc + 1;
        @(posedge clk); #1 c1_valid = 1'b0;
        n = 0;
        while (!r1_valid && n < 100) begin @(negedge clk); n++; end
        chk("narrow_latency", 64'(cyc - hs), 64'd10);
        chk("narrow_data", 64'(r1_data), 64'd1);
        @(posedge clk); #1 r1_ready = 1'b1;
        @(posedge clk); #1 r1_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
